jtag_user_dr_bridge: RTL and testbench



---
 rtl/jtag_dr_pkg.sv | 28 ++
 rtl/jtag_user_dr_bridge_if.sv | 32 +++
 rtl/jtag_in_sync.sv | 43 ++++
 rtl/jtag_user_dr_bridge.sv | 169 ++++++++++++++++
 tb/tb_jtag_user_dr_bridge.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_dr_pkg.sv
// Shared definitions for the JTAG user-DR bridge.
//   op_e    : command field carried in the top two bits of the data register
//   state_e : bus-side request state machine
//   STAT_*  : bit positions of the status pair loaded into the DR on capture
//   dr_width: total DR length for a given address/data width
package jtag_dr_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_RD  = 2'b01,
    OP_WR  = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } state_e;

  localparam int STAT_BUSY = 0;
  localparam int STAT_ERR  = 1;

  function automatic int dr_width(input int addr_w, input int data_w);
    return 2 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/jtag_user_dr_bridge_if.sv
// SoC bus request/response channel driven by the JTAG user-DR bridge.
//   req_valid/req_ready : request handshake, payload held while valid && !ready
//   req_write           : 1 = write, 0 = read
//   req_addr/req_wdata  : request payload
//   rsp_valid           : single-cycle response strobe
//   rsp_err/rsp_rdata   : response status and read data, qualified by rsp_valid
// master = the bridge, slave = the bus fabric.
interface jtag_user_dr_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );

endinterface

// File: rtl/jtag_in_sync.sv
// Multi-flop synchroniser for one asynchronous JTAG pin, with registered
// single-cycle edge pulses.
//   clk, reset : system clock, synchronous active-high reset
//   din        : raw asynchronous pin
//   dout       : synchronised level (after STAGES flops)
//   rise, fall : one-clk pulses when the synchronised level goes 0->1 / 1->0
module jtag_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      // prev_q holds the previous synchronised level; the edge pulses are
      // registered so every consumer sees a clean one-cycle strobe.
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/jtag_user_dr_bridge.sv
// Bridge from a BSCAN user data register to a single-master SoC bus.
// The JTAG strobes (including TCK) are oversampled in the clk domain; a DR of
// {op[1:0], addr, data} is shifted LSB first and each UPDATE turns into at
// most one bus request.
//   clk, reset      : system clock (>= 4x TCK), synchronous active-high reset
//   jtag_sel        : user register selected
//   jtag_capture    : capture-DR  -> DR <= {err, busy, 0, last read data}
//   jtag_shift      : shift-DR    -> DR <= {tdi, DR[DR_W-1:1]} on TCK rise
//   jtag_update     : update-DR   -> decode DR op (nop/read/write/clear err)
//   jtag_tck/tdi    : JTAG clock and serial input, both sampled as data
//   jtag_tdo        : serial output, reloaded from DR[0] on TCK fall
//   bus             : request/response channel (master side)
module jtag_user_dr_bridge
  import jtag_dr_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic jtag_sel,
  input  logic jtag_capture,
  input  logic jtag_shift,
  input  logic jtag_update,
  input  logic jtag_tck,
  input  logic jtag_tdi,
  output logic jtag_tdo,
  jtag_user_dr_bridge_if.master bus
);

  localparam int DR_W = dr_width(ADDR_W, DATA_W);

  // Synchronised JTAG levels and edges
  logic sel_s, cap_s, shf_s, upd_s, tck_s, tdi_s;
  logic tck_rise, tck_fall, upd_rise, upd_fall;
  logic sel_rise, sel_fall, cap_rise, cap_fall;
  logic shf_rise, shf_fall, tdi_rise, tdi_fall;

  jtag_in_sync #(.STAGES(SYNC_STAGES)) u_sync_tck (
    .clk(clk), .reset(reset), .din(jtag_tck),
    .dout(tck_s), .rise(tck_rise), .fall(tck_fall));

  jtag_in_sync #(.STAGES(SYNC_STAGES)) u_sync_tdi (
    .clk(clk), .reset(reset), .din(jtag_tdi),
    .dout(tdi_s), .rise(tdi_rise), .fall(tdi_fall));

  jtag_in_sync #(.STAGES(SYNC_STAGES)) u_sync_sel (
    .clk(clk), .reset(reset), .din(jtag_sel),
    .dout(sel_s), .rise(sel_rise), .fall(sel_fall));

  jtag_in_sync #(.STAGES(SYNC_STAGES)) u_sync_cap (
    .clk(clk), .reset(reset), .din(jtag_capture),
    .dout(cap_s), .rise(cap_rise), .fall(cap_fall));

  jtag_in_sync #(.STAGES(SYNC_STAGES)) u_sync_shf (
    .clk(clk), .reset(reset), .din(jtag_shift),
    .dout(shf_s), .rise(shf_rise), .fall(shf_fall));

  jtag_in_sync #(.STAGES(SYNC_STAGES)) u_sync_upd (
    .clk(clk), .reset(reset), .din(jtag_update),
    .dout(upd_s), .rise(upd_rise), .fall(upd_fall));

  // Only TCK edges, the UPDATE rise and the other levels are consumed.
  logic edges_unused;
  assign edges_unused = ^{tck_s, upd_s, upd_fall, sel_rise, sel_fall,
                          cap_rise, cap_fall, shf_rise, shf_fall,
                          tdi_rise, tdi_fall};

  // State
  state_e            state_q, state_d;
  logic [DR_W-1:0]   dr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              tdo_q;
  logic              req_write_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;

  // DR field decode
  op_e               upd_op;
  logic [ADDR_W-1:0] dr_addr;
  logic [DATA_W-1:0] dr_data;
  assign upd_op  = op_e'(dr_q[DR_W-1 -: 2]);
  assign dr_addr = dr_q[DATA_W +: ADDR_W];
  assign dr_data = dr_q[DATA_W-1:0];

  logic busy;
  logic [1:0] status;
  assign busy              = (state_q != IDLE);
  assign status[STAT_BUSY] = busy;
  assign status[STAT_ERR]  = err_q;

  logic upd_fire, cmd_go, take_cmd, overrun, clr_cmd, rsp_take, err_set;
  assign upd_fire = upd_rise & sel_s;
  assign cmd_go   = upd_fire & ((upd_op == OP_RD) | (upd_op == OP_WR));
  assign take_cmd = cmd_go & (state_q == IDLE);
  // A command arriving while a transfer is outstanding is dropped and flagged.
  assign overrun  = cmd_go & busy;
  assign clr_cmd  = upd_fire & (upd_op == OP_CLR);
  // Responses only count while a response is actually expected.
  assign rsp_take = (state_q == WAIT) & bus.rsp_valid;
  assign err_set  = (rsp_take & bus.rsp_err) | overrun;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take_cmd)       state_d = REQ;
      REQ:     if (bus.req_ready)  state_d = WAIT;
      WAIT:    if (bus.rsp_valid)  state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Request payload, held stable for the whole REQ phase
  always_ff @(posedge clk) begin
    if (reset) begin
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else if (take_cmd) begin
      req_write_q <= (upd_op == OP_WR);
      req_addr_q  <= dr_addr;
      req_wdata_q <= dr_data;
    end
  end

  // Read data and sticky error; a simultaneous set beats a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (rsp_take && !req_write_q) rdata_q <= bus.rsp_rdata;
      if (err_set)      err_q <= 1'b1;
      else if (clr_cmd) err_q <= 1'b0;
    end
  end

  // Data register: capture has priority over shift
  always_ff @(posedge clk) begin
    if (reset) begin
      dr_q <= '0;
    end else if (tck_rise && sel_s) begin
      if (cap_s)      dr_q <= {status, {ADDR_W{1'b0}}, rdata_q};
      else if (shf_s) dr_q <= {tdi_s, dr_q[DR_W-1:1]};
    end
  end

  // TDO is reloaded on the falling TCK so the host sees it settled at rise
  always_ff @(posedge clk) begin
    if (reset)                  tdo_q <= 1'b0;
    else if (tck_fall && sel_s) tdo_q <= dr_q[0];
  end

  assign jtag_tdo      = tdo_q;
  assign bus.req_valid = (state_q == REQ);
  assign bus.req_write = req_write_q;
  assign bus.req_addr  = req_addr_q;
  assign bus.req_wdata = req_wdata_q;

endmodule

// File: tb/tb_jtag_user_dr_bridge.sv
// Self-checking bench for jtag_user_dr_bridge: drives the BSCAN pins as a
// host would, answers bus requests from a memory model and compares captured
// DR contents and bus requests against a command-level reference model.
module tb_jtag_user_dr_bridge;
  import jtag_dr_pkg::*;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 32;
  localparam int SYNC_STAGES = 2;
  localparam int DR_W        = dr_width(ADDR_W, DATA_W);
  localparam int H           = 6;   // clk cycles per TCK half period

  logic clk = 1'b0;
  logic reset;
  logic jtag_sel, jtag_capture, jtag_shift, jtag_update, jtag_tck, jtag_tdi;
  logic jtag_tdo;

  jtag_user_dr_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  jtag_user_dr_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .reset(reset),
    .jtag_sel(jtag_sel), .jtag_capture(jtag_capture),
    .jtag_shift(jtag_shift), .jtag_update(jtag_update),
    .jtag_tck(jtag_tck), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  int checks = 0;
  int errors = 0;

  req_t        hs_q[$];     // every accepted request, for checking
  req_t        pend_q[$];   // accepted requests awaiting a response
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        err_inject = 1'b0;
  int          rsp_count = 0;
  int          rsp_dly = 0;
  int          exp_rsp = 0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_rdata = 32'h0;

  // Handshake monitor
  always @(posedge clk) begin
    if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) begin
      hs_q.push_back({bus.req_write, bus.req_addr, bus.req_wdata});
      pend_q.push_back({bus.req_write, bus.req_addr, bus.req_wdata});
    end
  end

  // Bus responder with a random 0..3 cycle response delay
  always @(negedge clk) begin
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = $urandom;
    if (pend_q.size() > 0) begin
      if (rsp_dly == 0) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_inject;
        bus.rsp_rdata = mem[pend_q[0].addr];
        if (pend_q[0].write) mem[pend_q[0].addr] = pend_q[0].wdata;
        void'(pend_q.pop_front());
        rsp_count++;
        rsp_dly = int'($urandom_range(0, 3));
      end else begin
        rsp_dly--;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [DR_W-1:0] mk(input logic [1:0] op, input logic [7:0] a,
                                         input logic [31:0] d);
    return {op, a, d};
  endfunction

  function automatic logic [DR_W-1:0] cap_exp(input logic err, input logic bsy,
                                              input logic [31:0] rd);
    return {err, bsy, 8'h00, rd};
  endfunction

  function automatic req_t mk_req(input logic w, input logic [7:0] a, input logic [31:0] d);
    req_t r;
    r = {w, a, d};
    return r;
  endfunction

  // Capture-DR then shift DR_W bits: din goes in, the captured DR comes out.
  task automatic scan(input logic [DR_W-1:0] din, output logic [DR_W-1:0] dout);
    dout = '0;
    jtag_sel = 1'b1; jtag_capture = 1'b1; jtag_shift = 1'b0;
    tick(H); jtag_tck = 1'b1; tick(H); jtag_tck = 1'b0;
    jtag_capture = 1'b0; jtag_shift = 1'b1;
    for (int i = 0; i < DR_W; i++) begin
      jtag_tdi = din[i];
      tick(H);
      dout[i] = jtag_tdo;
      jtag_tck = 1'b1;
      tick(H);
      jtag_tck = 1'b0;
    end
    jtag_shift = 1'b0;
    tick(H);
  endtask

  task automatic pulse_update();
    jtag_update = 1'b1; tick(H);
    jtag_update = 1'b0; tick(H);
  endtask

  task automatic wait_hs(input string tag, input req_t expv);
    req_t r;
    int n = 0;
    while (hs_q.size() == 0 && n < 100) begin tick(1); n++; end
    check({tag, "_present"}, 64'(hs_q.size() > 0), 64'(1'b1));
    if (hs_q.size() > 0) begin
      r = hs_q.pop_front();
      check(tag, 64'(r), 64'(expv));
    end
  endtask

  task automatic wait_rsp();
    int n = 0;
    exp_rsp++;
    while (rsp_count < exp_rsp && n < 100) begin tick(1); n++; end
    check("rsp_seen", 64'(rsp_count), 64'(exp_rsp));
    tick(2);
  endtask

  // One full host transaction checked against the model
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d);
    logic [DR_W-1:0] got;
    scan(mk(op, a, d), got);
    check("rand_capture", 64'(got), 64'(cap_exp(exp_err, 1'b0, exp_rdata)));
    pulse_update();
    if (op == OP_RD || op == OP_WR) begin
      wait_hs("rand_req", mk_req(op == OP_WR, a, d));
      wait_rsp();
      if (op == OP_WR) ref_mem[a] = d;
      else             exp_rdata = ref_mem[a];
      if (err_inject) exp_err = 1'b1;
    end else begin
      tick(20);
      check("rand_no_req", 64'(hs_q.size()), 64'(0));
      if (op == OP_CLR) exp_err = 1'b0;
    end
  endtask

  initial begin
    logic [DR_W-1:0] got;
    logic [DR_W-1:0] held;
    logic            tdo_before;
    int              n;

    reset = 1'b1;
    jtag_sel = 1'b0; jtag_capture = 1'b0; jtag_shift = 1'b0;
    jtag_update = 1'b0; jtag_tck = 1'b0; jtag_tdi = 1'b0;
    bus.req_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      mem[i]     = ref_mem[i];
    end

    // Reset with TCK toggling
    for (int c = 0; c < 3; c++) begin
      tick(1);
      jtag_tck = ~jtag_tck;
      check("rst_tdo", 64'(jtag_tdo), 64'(1'b0));
      check("rst_req_valid", 64'(bus.req_valid), 64'(1'b0));
    end
    check("rst_req_write", 64'(bus.req_write), 64'(1'b0));
    check("rst_req_addr", 64'(bus.req_addr), 64'(0));
    check("rst_req_wdata", 64'(bus.req_wdata), 64'(0));
    reset = 1'b0;
    jtag_tck = 1'b0;
    tick(5);
    check("rst_no_bus", 64'(hs_q.size()), 64'(0));

    // Write 0x3C <= DEADBEEF; req_valid 4 clk after the update pin
    scan(mk(OP_WR, 8'h3C, 32'hDEADBEEF), got);
    check("cap_after_reset", 64'(got), 64'(cap_exp(1'b0, 1'b0, 32'h0)));
    jtag_update = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      check("lat_req_valid", 64'(bus.req_valid), 64'(k == 4));
    end
    check("wr_write", 64'(bus.req_write), 64'(1'b1));
    check("wr_addr", 64'(bus.req_addr), 64'(8'h3C));
    check("wr_wdata", 64'(bus.req_wdata), 64'(32'hDEADBEEF));
    tick(1);
    check("wr_valid_drops", 64'(bus.req_valid), 64'(1'b0));
    jtag_update = 1'b0;
    wait_hs("wr_req", mk_req(1'b1, 8'h3C, 32'hDEADBEEF));
    wait_rsp();
    ref_mem[8'h3C] = 32'hDEADBEEF;
    tick(20);
    check("wr_single_req", 64'(hs_q.size()), 64'(0));

    // Read 0x10 returning 12345678
    ref_mem[8'h10] = 32'h12345678;
    mem[8'h10]     = 32'h12345678;
    scan(mk(OP_RD, 8'h10, 32'h0), got);
    check("rd_capture", 64'(got), 64'(cap_exp(exp_err, 1'b0, exp_rdata)));
    pulse_update();
    wait_hs("rd_req", mk_req(1'b0, 8'h10, 32'h0));
    wait_rsp();
    exp_rdata = ref_mem[8'h10];
    scan(mk(OP_NOP, 8'h0, 32'h0), got);
    check("rd_data", 64'(got[31:0]), 64'(32'h12345678));
    check("rd_zero_addr", 64'(got[39:32]), 64'(8'h00));
    check("rd_status", 64'(got[41:40]), 64'(2'b00));

    // Back-pressure: payload held 10 clk, second update overruns
    bus.req_ready = 1'b0;
    scan(mk(OP_WR, 8'h55, 32'hA5A50F0F), got);
    check("hold_capture", 64'(got), 64'(cap_exp(exp_err, 1'b0, exp_rdata)));
    jtag_update = 1'b1;
    n = 0;
    while (bus.req_valid !== 1'b1 && n < 20) begin tick(1); n++; end
    check("hold_start", 64'(bus.req_valid), 64'(1'b1));
    jtag_update = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) jtag_update = 1'b1;
      if (c == 7) jtag_update = 1'b0;
      tick(1);
      check("hold_valid", 64'(bus.req_valid), 64'(1'b1));
      check("hold_payload", 64'({bus.req_write, bus.req_addr, bus.req_wdata}),
            64'(mk_req(1'b1, 8'h55, 32'hA5A50F0F)));
    end
    exp_err = 1'b1;
    tick(H);
    scan(mk(OP_NOP, 8'h0, 32'h0), got);
    check("ovr_status", 64'(got[41:40]), 64'(2'b11));
    check("ovr_capture", 64'(got), 64'(cap_exp(1'b1, 1'b1, exp_rdata)));
    bus.req_ready = 1'b1;
    wait_hs("hold_req", mk_req(1'b1, 8'h55, 32'hA5A50F0F));
    wait_rsp();
    ref_mem[8'h55] = 32'hA5A50F0F;
    tick(20);
    check("ovr_dropped", 64'(hs_q.size()), 64'(0));

    // Clear, then a write answered with an error, then clear again
    issue(OP_CLR, 8'h00, 32'h0);
    err_inject = 1'b1;
    issue(OP_WR, 8'h07, 32'h11223344);
    err_inject = 1'b0;
    scan(mk(OP_CLR, 8'h0, 32'h0), got);
    check("err_status", 64'(got[41:40]), 64'(2'b10));
    pulse_update();
    exp_err = 1'b0;
    scan(mk(OP_NOP, 8'h0, 32'h0), got);
    check("clr_status", 64'(got[41:40]), 64'(2'b00));

    // Random commands against the model
    for (int t = 0; t < 10; t++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      err_inject = ($urandom_range(0, 3) == 0);
      issue(op, 8'($urandom), $urandom);
    end
    err_inject = 1'b0;

    // sel low: DR, TDO and bus untouched
    held = mk(OP_WR, 8'($urandom), $urandom);
    scan(held, got);
    check("sel_capture", 64'(got), 64'(cap_exp(exp_err, 1'b0, exp_rdata)));
    jtag_sel = 1'b0;
    tdo_before = jtag_tdo;
    jtag_shift = 1'b1;
    for (int c = 0; c < 6; c++) begin
      jtag_capture = (c == 0);
      jtag_tdi = 1'($urandom);
      tick(H); jtag_tck = 1'b1; tick(H); jtag_tck = 1'b0;
    end
    jtag_capture = 1'b0;
    jtag_shift = 1'b0;
    pulse_update();
    tick(20);
    check("sel0_tdo", 64'(jtag_tdo), 64'(tdo_before));
    check("sel0_no_req", 64'(hs_q.size()), 64'(0));
    jtag_sel = 1'b1;
    tick(H);
    pulse_update();
    wait_hs("sel0_dr_kept", mk_req(1'b1, held[39:32], held[31:0]));
    wait_rsp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
